pc_gen: RTL and testbench
=========================

Name: pc_gen

Overview:
- Program-counter stage directly downstream of the branch-condition logic.
- Consumes the adder operand selects (pc_a_src, pc_b_src) with imm and rs1 data, and computes the next PC.
- Holds the architectural PC register and issues fetch requests to the IFU over a valid/ready handshake.
- Advances only when the core signals commit; halts on a halt request; redirects to a trap vector on a misaligned target.

Parameters:
- XLEN, 32, data/address width.
- RESET_PC, 32'h8000_0000, PC value loaded on reset.
- TRAP_VEC, 32'h8000_0100, PC loaded when a misaligned target is detected.

Ports:
- clk  input  1  core clock; all state updates on rising edge.
- rst_n  input  1  asynchronous, active-low reset.
- pc_a_src  input  1  adder A select: 0 = constant 4, 1 = imm.
- pc_b_src  input  1  adder B select: 0 = current pc, 1 = rs1_data.
- imm  input  XLEN  sign-extended immediate from decode.
- rs1_data  input  XLEN  register rs1 read value.
- commit_valid  input  1  current instruction retires this cycle; sample selects/operands.
- halt_req  input  1  ebreak/halt from decode; takes effect on commit.
- if_req_valid  output  1  fetch request for address pc is valid.
- if_req_ready  input  1  IFU accepts request.
- pc  output  XLEN  current PC.
- misalign  output  1  one-cycle pulse: computed target not 4-byte aligned.
- halted  output  1  core stopped; sticky until reset.

Behaviour:
- Reset (async, rst_n low):
  - pc = RESET_PC, state = FETCH, if_req_valid = 0, misalign = 0, halted = 0.
  - Asserting rst_n low mid-operation aborts any pending request immediately; nothing is retained.
- First cycle after reset release: if_req_valid = 1.
- States: FETCH, EXEC, HALT.
- FETCH:
  - if_req_valid = 1 and pc held stable.
  - On if_req_valid & if_req_ready: go to EXEC, if_req_valid = 0 next cycle.
  - if_req_valid stays high until accepted; pc must not change while it is high.
- EXEC:
  - if_req_valid = 0. Wait for commit_valid; commit_valid in FETCH is ignored.
  - On commit_valid, compute: opA = pc_a_src ? imm : 4; opB = pc_b_src ? rs1_data : pc; sum = (opA + opB) mod 2^XLEN, wrap-around silent.
  - If pc_b_src = 1, target = {sum[XLEN-1:1], 1'b0}; otherwise target = sum.
  - If halt_req = 1 in the commit cycle: pc unchanged, go to HALT. halt_req has priority over misalign.
  - Else if target[1:0] != 0: pc = TRAP_VEC, misalign pulses for exactly one cycle (the cycle after commit), go to FETCH.
  - Else: pc = target, go to FETCH.
- HALT: halted = 1, if_req_valid = 0. All inputs ignored; exit only via reset.
- Latency: commit edge → new pc and if_req_valid = 1 on the next cycle. Minimum 2 cycles per instruction when if_req_ready is tied high.
- Simultaneous if_req_ready and commit_valid in FETCH: the handshake completes; commit_valid is ignored.

Optional Feature:
- Macro: PCGEN_REDIRECT_CNT_EN.
- Defined:
  - Adds output redirect_cnt [31:0].
  - Reset to 0 by rst_n.
  - Increments by 1 on each committed, non-halting instruction whose selects are not (pc_a_src = 0, pc_b_src = 0), including misaligned ones; wraps from 32'hFFFF_FFFF to 0.
- Undefined: port and counter absent; all other behaviour identical.

Test Plan:
- Reset then if_req_ready = 1, commit with selects 0/0 each EXEC → pc sequence 8000_0000, 8000_0004, 8000_0008; if_req_valid high every other cycle.
- Branch: pc = 8000_0010, pc_a_src = 1, pc_b_src = 0, imm = FFFF_FFF0 → pc = 8000_0000.
- JALR: pc_a_src = 1, pc_b_src = 1, rs1_data = 8000_0201, imm = 3 → pc = 8000_0204 (bit 0 cleared), no misalign.
- Misalign: pc_a_src = 1, pc_b_src = 0, imm = 2 from pc = 8000_0000 → pc = 8000_0100, misalign high for exactly 1 cycle.
- Backpressure plus halt:
  - Hold if_req_ready = 0 for 5 cycles → if_req_valid and pc stable throughout.
  - Then accept, commit with halt_req = 1 → halted = 1, pc unchanged, no further requests.
  - rst_n low mid-HALT → pc = 8000_0000, halted = 0 asynchronously.
- With PCGEN_REDIRECT_CNT_EN: 3 sequential commits + 2 branches → redirect_cnt = 2.

Source files
------------

// File: rtl/pc_gen.sv
// pc_gen: program-counter stage that sits directly after the branch-condition logic.
// It holds the architectural PC and issues fetch requests to the IFU over a
// valid/ready handshake. When the core commits an instruction it computes the
// next PC as (pc_a_src ? imm : 4) + (pc_b_src ? rs1_data : pc). A halt request
// stops the core until reset. A target that is not 4-byte aligned redirects
// the PC to TRAP_VEC.
// Optional build macro PCGEN_REDIRECT_CNT_EN adds the redirect_cnt output. It
// counts committed, non-halting instructions that did not use the sequential
// (4 + pc) selects.
module pc_gen #(
    parameter int              XLEN     = 32,
    parameter logic [XLEN-1:0] RESET_PC = 32'h8000_0000,
    parameter logic [XLEN-1:0] TRAP_VEC = 32'h8000_0100
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            pc_a_src,
    input  logic            pc_b_src,
    input  logic [XLEN-1:0] imm,
    input  logic [XLEN-1:0] rs1_data,
    input  logic            commit_valid,
    input  logic            halt_req,
    output logic            if_req_valid,
    input  logic            if_req_ready,
    output logic [XLEN-1:0] pc,
    output logic            misalign,
    output logic            halted
`ifdef PCGEN_REDIRECT_CNT_EN
    ,
    output logic [31:0]     redirect_cnt
`endif
);

    localparam logic [XLEN-1:0] PC_STEP = XLEN'(4);

    typedef enum logic [1:0] {
        ST_FETCH = 2'd0,
        ST_EXEC  = 2'd1,
        ST_HALT  = 2'd2
    } state_t;

    state_t          state_q, state_d;
    logic [XLEN-1:0] pc_q, pc_d;
    logic            vld_q, vld_d;
    logic            mis_q, mis_d;

    logic [XLEN-1:0] op_a;
    logic [XLEN-1:0] op_b;
    logic [XLEN-1:0] sum;
    logic [XLEN-1:0] target;
    logic            tgt_misaligned;
    logic            fetch_fire;
    logic            commit_fire;

    // Handshake and commit qualifiers. A commit outside EXEC is ignored.
    // The request only counts once it has actually been presented (vld_q).
    assign fetch_fire  = (state_q == ST_FETCH) && vld_q && if_req_ready;
    assign commit_fire = (state_q == ST_EXEC) && commit_valid;

    // Next-PC adder. The wrap-around at 2^XLEN is intentional.
    // Register-relative jumps (pc_b_src) drop bit 0, as JALR does.
    always_comb begin
        op_a           = pc_a_src ? imm : PC_STEP;
        op_b           = pc_b_src ? rs1_data : pc_q;
        sum            = op_a + op_b;
        target         = sum;
        if (pc_b_src) begin
            target[0] = 1'b0;
        end
        tgt_misaligned = (target[1:0] != 2'b00);
    end

    // Next-state, next-PC, request-valid and misalign-pulse logic.
    always_comb begin
        state_d = state_q;
        pc_d    = pc_q;
        mis_d   = 1'b0;
        case (state_q)
            ST_FETCH: begin
                // pc is frozen while the request is outstanding.
                if (fetch_fire) begin
                    state_d = ST_EXEC;
                end
            end
            ST_EXEC: begin
                if (commit_fire) begin
                    if (halt_req) begin
                        // Halt wins over a misaligned target, and pc stays put.
                        state_d = ST_HALT;
                    end else if (tgt_misaligned) begin
                        state_d = ST_FETCH;
                        pc_d    = TRAP_VEC;
                        mis_d   = 1'b1;
                    end else begin
                        state_d = ST_FETCH;
                        pc_d    = target;
                    end
                end
            end
            ST_HALT: begin
                state_d = ST_HALT;
            end
            default: begin
                state_d = ST_FETCH;
            end
        endcase
        // The request is registered, so it rises the cycle after entering FETCH.
        // This also keeps it low while reset is asserted.
        vld_d = (state_d == ST_FETCH);
    end

    // State, PC, request-valid and misalign registers with async active-low reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_FETCH;
            pc_q    <= RESET_PC;
            vld_q   <= 1'b0;
            mis_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            vld_q   <= vld_d;
            mis_q   <= mis_d;
        end
    end

`ifdef PCGEN_REDIRECT_CNT_EN
    logic [31:0] rcnt_q, rcnt_d;
    logic        redirect_evt;

    // A redirect is any non-halting commit that does not use the 4 + pc selects.
    // Misaligned targets count as redirects.
    assign redirect_evt = commit_fire && !halt_req && (pc_a_src || pc_b_src);

    // Next value of the redirect counter. It wraps silently at 2^32.
    always_comb begin
        rcnt_d = rcnt_q;
        if (redirect_evt) begin
            rcnt_d = rcnt_q + 32'd1;
        end
    end

    // Redirect counter register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rcnt_q <= 32'd0;
        end else begin
            rcnt_q <= rcnt_d;
        end
    end

    assign redirect_cnt = rcnt_q;
`else
    // No redirect counter in this build.
`endif

    assign if_req_valid = vld_q;
    assign pc           = pc_q;
    assign misalign     = mis_q;
    assign halted       = (state_q == ST_HALT);

endmodule

// File: tb/tb_pc_gen.sv
// tb_pc_gen: scoreboard-based bench for pc_gen. The expected PC and misalign
// value are queued when a commit is driven. They are popped and compared on
// the cycle the DUT presents the new PC.
module tb_pc_gen;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        pc_a_src;
    logic        pc_b_src;
    logic [31:0] imm;
    logic [31:0] rs1_data;
    logic        commit_valid;
    logic        halt_req;
    logic        if_req_valid;
    logic        if_req_ready;
    logic [31:0] pc;
    logic        misalign;
    logic        halted;
`ifdef PCGEN_REDIRECT_CNT_EN
    logic [31:0] redirect_cnt;
`endif

    pc_gen dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .pc_a_src     (pc_a_src),
        .pc_b_src     (pc_b_src),
        .imm          (imm),
        .rs1_data     (rs1_data),
        .commit_valid (commit_valid),
        .halt_req     (halt_req),
        .if_req_valid (if_req_valid),
        .if_req_ready (if_req_ready),
        .pc           (pc),
        .misalign     (misalign),
        .halted       (halted)
`ifdef PCGEN_REDIRECT_CNT_EN
        ,
        .redirect_cnt (redirect_cnt)
`endif
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [31:0] pc;
        logic        mis;
    } exp_t;

    exp_t        sb_q[$];
    int          n_tests = 0;
    int          n_fail  = 0;
    logic [31:0] cur_pc;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_valid(input int budget);
        for (int i = 0; i < budget && if_req_valid !== 1'b1; i++) begin
            step();
        end
        chk("wait_vld", 32'(if_req_valid), 32'd1);
    endtask

    // Drive one commit in EXEC, then check the result against the scoreboard.
    task automatic commit_op(input logic a, input logic b, input logic [31:0] imm_v,
                             input logic [31:0] rs1_v, input logic halt,
                             input logic [31:0] exp_pc, input logic exp_mis);
        exp_t e;
        pc_a_src     = a;
        pc_b_src     = b;
        imm          = imm_v;
        rs1_data     = rs1_v;
        halt_req     = halt;
        commit_valid = 1'b1;
        sb_q.push_back('{pc: exp_pc, mis: exp_mis});
        step();
        commit_valid = 1'b0;
        halt_req     = 1'b0;
        if (sb_q.size() == 0) begin
            chk("sb_empty", 32'd0, 32'd1);
        end else begin
            e = sb_q.pop_front();
            chk("pc", pc, e.pc);
            chk("misalign", 32'(misalign), 32'(e.mis));
        end
        chk("halted", 32'(halted), 32'(halt));
        if (!halt) begin
            chk("next_vld", 32'(if_req_valid), 32'd1);
            // With the request held off, misalign must drop and pc must stay put.
            if_req_ready = 1'b0;
            step();
            chk("mis_pulse", 32'(misalign), 32'd0);
            chk("pc_hold", pc, exp_pc);
        end
        cur_pc = exp_pc;
    endtask

    // Complete a fetch handshake, idle in EXEC for some cycles, then commit.
    task automatic instr(input logic a, input logic b, input logic [31:0] imm_v,
                         input logic [31:0] rs1_v, input int idle,
                         input logic [31:0] exp_pc, input logic exp_mis);
        if_req_ready = 1'b1;
        wait_valid(20);
        step();
        if_req_ready = 1'b0;
        chk("exec_vld", 32'(if_req_valid), 32'd0);
        for (int i = 0; i < idle; i++) begin
            step();
            chk("exec_idle_pc", pc, cur_pc);
            chk("exec_idle_vld", 32'(if_req_valid), 32'd0);
        end
        commit_op(a, b, imm_v, rs1_v, 1'b0, exp_pc, exp_mis);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n        = 1'b0;
        pc_a_src     = 1'b0;
        pc_b_src     = 1'b0;
        imm          = 32'd0;
        rs1_data     = 32'd0;
        commit_valid = 1'b0;
        halt_req     = 1'b0;
        if_req_ready = 1'b0;
        cur_pc       = 32'h8000_0000;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_pc", pc, 32'h8000_0000);
        chk("rst_vld", 32'(if_req_valid), 32'd0);
        chk("rst_mis", 32'(misalign), 32'd0);
        chk("rst_halted", 32'(halted), 32'd0);
`ifdef PCGEN_REDIRECT_CNT_EN
        chk("rst_cnt", redirect_cnt, 32'd0);
`endif
        @(negedge clk);
        rst_n = 1'b1;
        step();
        chk("post_rst_vld", 32'(if_req_valid), 32'd1);
        chk("post_rst_pc", pc, 32'h8000_0000);

        // Sequential flow.
        instr(1'b0, 1'b0, 32'h0, 32'h0, 0, 32'h8000_0004, 1'b0);
        instr(1'b0, 1'b0, 32'h0, 32'h0, 2, 32'h8000_0008, 1'b0);
        instr(1'b0, 1'b0, 32'h0, 32'h0, 0, 32'h8000_000C, 1'b0);
        instr(1'b0, 1'b0, 32'h0, 32'h0, 0, 32'h8000_0010, 1'b0);
        // Backward branch.
        instr(1'b1, 1'b0, 32'hFFFF_FFF0, 32'h0, 0, 32'h8000_0000, 1'b0);
        // Misaligned branch redirects to the trap vector.
        instr(1'b1, 1'b0, 32'h0000_0002, 32'h0, 0, 32'h8000_0100, 1'b1);
        // JALR: bit 0 of the sum is cleared.
        instr(1'b1, 1'b1, 32'h0000_0003, 32'h8000_0201, 1, 32'h8000_0204, 1'b0);
        // The adder wraps silently.
        instr(1'b1, 1'b0, 32'h8000_0000, 32'h0, 0, 32'h0000_0204, 1'b0);
        instr(1'b1, 1'b1, 32'h0000_0000, 32'h8000_0000, 0, 32'h8000_0000, 1'b0);
        // 4 + rs1 with bit 1 set: misaligned even after bit 0 is cleared.
        instr(1'b0, 1'b1, 32'h0, 32'h1000_0002, 0, 32'h8000_0100, 1'b1);
`ifdef PCGEN_REDIRECT_CNT_EN
        chk("cnt_main", redirect_cnt, 32'd6);
`endif

        // Backpressure. A commit while in FETCH is ignored.
        if_req_ready = 1'b0;
        for (int i = 0; i < 5; i++) begin
            commit_valid = (i == 2);
            pc_a_src     = 1'b1;
            imm          = 32'h40;
            step();
            chk("bp_vld", 32'(if_req_valid), 32'd1);
            chk("bp_pc", pc, 32'h8000_0100);
        end
        // Handshake and commit in the same cycle: only the handshake takes effect.
        if_req_ready = 1'b1;
        commit_valid = 1'b1;
        step();
        if_req_ready = 1'b0;
        commit_valid = 1'b0;
        chk("hs_vld", 32'(if_req_valid), 32'd0);
        chk("hs_pc", pc, 32'h8000_0100);
        // Halt takes priority over a misaligned target.
        commit_op(1'b1, 1'b0, 32'h2, 32'h0, 1'b1, 32'h8000_0100, 1'b0);
        if_req_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            commit_valid = 1'b1;
            pc_a_src     = 1'b1;
            imm          = 32'h8;
            step();
            chk("halt_vld", 32'(if_req_valid), 32'd0);
            chk("halt_pc", pc, 32'h8000_0100);
            chk("halt_sticky", 32'(halted), 32'd1);
        end
        commit_valid = 1'b0;
`ifdef PCGEN_REDIRECT_CNT_EN
        chk("cnt_halt", redirect_cnt, 32'd6);
`endif

        // Asynchronous reset in the middle of HALT.
        @(posedge clk);
        #3;
        rst_n = 1'b0;
        #1;
        chk("arst_pc", pc, 32'h8000_0000);
        chk("arst_halted", 32'(halted), 32'd0);
        chk("arst_vld", 32'(if_req_valid), 32'd0);
`ifdef PCGEN_REDIRECT_CNT_EN
        chk("arst_cnt", redirect_cnt, 32'd0);
`endif
        @(negedge clk);
        rst_n  = 1'b1;
        cur_pc = 32'h8000_0000;
        step();
        chk("rerun_vld", 32'(if_req_valid), 32'd1);

        // Three sequential commits and two branches.
        instr(1'b0, 1'b0, 32'h0, 32'h0, 0, 32'h8000_0004, 1'b0);
        instr(1'b0, 1'b0, 32'h0, 32'h0, 0, 32'h8000_0008, 1'b0);
        instr(1'b0, 1'b0, 32'h0, 32'h0, 0, 32'h8000_000C, 1'b0);
        instr(1'b1, 1'b0, 32'hFFFF_FFF0, 32'h0, 0, 32'h7FFF_FFFC, 1'b0);
        instr(1'b1, 1'b0, 32'h0000_0004, 32'h0, 0, 32'h8000_0000, 1'b0);
`ifdef PCGEN_REDIRECT_CNT_EN
        chk("cnt_two", redirect_cnt, 32'd2);
`endif

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
